dmem_arbiter: RTL and testbench

Shares one data-memory port among `N_MASTERS` hart-side data-memory interfaces in multi-hart builds. It sits between each hart's data-memory stage and the single memory/bus slave. It accepts one outstanding transaction at a time and locks the grant until the slave returns `i_DM_data_ready`. It then routes read data and ready back to the winning hart only, so each hart's own stall logic keeps it waiting.

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arbiter_rr_prio_enc.sv | 26 ++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Provides a default XLEN when the build does not define one.
`ifndef XLEN
`define XLEN 32
`endif

package arvi_arb_pkg;

  localparam int unsigned MAX_MASTERS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [2:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_prio_enc.sv
// Rotating priority encoder: the first requester at or after `start` wins.
// With start tied to zero it degenerates to lowest-index-wins.
module rr_prio_enc #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  winner
);

  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!found && req[k] && (((32'(start) + i) % N) == k)) begin
          winner[k] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory slave port among N_MASTERS harts, one transaction at a time.
// Define ARVI_DMEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority.
module dmem_arbiter
  import arvi_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned XLEN      = `XLEN
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_MASTERS*XLEN-1:0] i_m_addr,
  input  logic [N_MASTERS*XLEN-1:0] i_m_wd,
  input  logic [N_MASTERS-1:0]      i_m_wen,
  input  logic [N_MASTERS-1:0]      i_m_rd,
  input  logic [N_MASTERS*4-1:0]    i_m_byte_en,
  output logic [XLEN-1:0]           o_m_rdata,
  output logic [N_MASTERS-1:0]      o_m_data_ready,
  output logic [XLEN-1:0]           o_DM_Addr,
  output logic [XLEN-1:0]           o_DM_Wd,
  output logic                      o_DM_Wen,
  output logic                      o_DM_MemRead,
  output logic [3:0]                o_DM_byte_en,
  input  logic [XLEN-1:0]           i_DM_ReadData,
  input  logic                      i_DM_data_ready
);

  localparam int unsigned PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  arb_state_t           state;
  logic [N_MASTERS-1:0] grant;
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] winner;
  logic [PW-1:0]        start_idx;
  logic                 busy;
  logic                 g_wen;
  logic                 g_rd;
  logic [XLEN-1:0]      mux_addr;
  logic [XLEN-1:0]      mux_wd;
  logic [3:0]           mux_be;

  assign req  = i_m_wen | i_m_rd;
  assign busy = (state == BUSY);

`ifdef ARVI_DMEM_ARB_RR_EN
  logic [PW-1:0] rr_ptr;
  logic [2:0]    win_idx;

  assign win_idx = onehot2idx(MAX_MASTERS'(winner));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rr_ptr <= '0;
    end else if (state == IDLE && |req) begin
      rr_ptr <= (32'(win_idx) == N_MASTERS - 1) ? '0 : PW'(32'(win_idx) + 1);
    end
  end

  assign start_idx = rr_ptr;
`else
  assign start_idx = '0;
`endif

  rr_prio_enc #(
    .N  (N_MASTERS),
    .IW (PW)
  ) u_prio (
    .req    (req),
    .start  (start_idx),
    .winner (winner)
  );

  // A granted master dropping both enables mid-transaction is an exception flush.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= winner;
            state <= BUSY;
          end else begin
            grant <= '0;
          end
        end
        BUSY: begin
          if (i_DM_data_ready || !(|(req & grant))) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    g_wen    = 1'b0;
    g_rd     = 1'b0;
    mux_addr = '0;
    mux_wd   = '0;
    mux_be   = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      g_wen    = g_wen | (grant[k] & i_m_wen[k]);
      g_rd     = g_rd  | (grant[k] & i_m_rd[k]);
      mux_addr = mux_addr | ({XLEN{grant[k]}} & i_m_addr[k*XLEN +: XLEN]);
      mux_wd   = mux_wd   | ({XLEN{grant[k]}} & i_m_wd[k*XLEN +: XLEN]);
      mux_be   = mux_be   | ({4{grant[k]}}    & i_m_byte_en[k*4 +: 4]);
    end
  end

  // Write wins when a master raises both enables.
  assign o_DM_Wen       = busy & g_wen;
  assign o_DM_MemRead   = busy & g_rd & ~g_wen;
  assign o_DM_Addr      = {XLEN{busy}} & mux_addr;
  assign o_DM_Wd        = {XLEN{busy}} & mux_wd;
  assign o_DM_byte_en   = {4{busy}} & mux_be;
  assign o_m_data_ready = {N_MASTERS{busy & i_DM_data_ready}} & grant;
  assign o_m_rdata      = i_DM_ReadData;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed masters, behavioural wait-state slave,
// and a decoupled monitor checking slave-side transactions and master responses.
module tb_dmem_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned XL = 32;
  localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [N*XL-1:0] m_addr, m_wd;
  logic [N-1:0]    m_wen, m_rd;
  logic [N*4-1:0]  m_be;
  logic [XL-1:0]   m_rdata;
  logic [N-1:0]    m_ready;
  logic [XL-1:0]   dm_addr, dm_wd, dm_rdata;
  logic            dm_wen, dm_rd, dm_ready;
  logic [3:0]      dm_be;

  int unsigned wait_states = 0;
  int unsigned busy_cnt = 0;
  logic        force_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [N-1:0] who;
    logic [31:0]  data;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        wen;
    logic        rd;
    logic [3:0]  be;
  } slv_t;

  resp_t resp_q[$];
  slv_t  slv_q[$];

  always #5 i_clk = ~i_clk;

  dmem_arbiter #(
    .N_MASTERS (N),
    .XLEN      (XL)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_m_addr        (m_addr),
    .i_m_wd          (m_wd),
    .i_m_wen         (m_wen),
    .i_m_rd          (m_rd),
    .i_m_byte_en     (m_be),
    .o_m_rdata       (m_rdata),
    .o_m_data_ready  (m_ready),
    .o_DM_Addr       (dm_addr),
    .o_DM_Wd         (dm_wd),
    .o_DM_Wen        (dm_wen),
    .o_DM_MemRead    (dm_rd),
    .o_DM_byte_en    (dm_be),
    .i_DM_ReadData   (dm_rdata),
    .i_DM_data_ready (dm_ready)
  );

  // Slave: ready after wait_states busy cycles, data derived from the address.
  assign dm_ready = force_ready | ((dm_wen | dm_rd) && (busy_cnt == wait_states));
  assign dm_rdata = dm_ready ? (dm_addr ^ RD_KEY) : '0;
  always @(posedge i_clk) busy_cnt <= ((dm_wen | dm_rd) && !dm_ready) ? busy_cnt + 1 : 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic slv_t mk_slv(input logic [31:0] a, input logic [31:0] d,
                                  input logic w, input logic r, input logic [3:0] b);
    slv_t s;
    s.addr = a; s.wd = d; s.wen = w; s.rd = r; s.be = b;
    return s;
  endfunction

  function automatic resp_t mk_resp(input logic [N-1:0] who, input logic [31:0] a);
    resp_t r;
    r.who = who; r.data = a ^ RD_KEY;
    return r;
  endfunction

  task automatic set_m(input int k, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    m_wen[k] = w;
    m_rd[k]  = r;
    m_addr[k*XL +: XL] = a;
    m_wd[k*XL +: XL]   = d;
    m_be[k*4 +: 4]     = b;
  endtask

  task automatic wait_rdy(input int k, input string name);
    int cyc;
    cyc = 0;
    while (1) begin
      @(negedge i_clk);
      cyc++;
      if (m_ready[k]) break;
      if (cyc >= 100) begin
        timeout_fail(name);
        break;
      end
    end
  endtask

  task automatic wait_busy(input string name);
    int cyc;
    cyc = 0;
    while (1) begin
      @(negedge i_clk);
      cyc++;
      if (dm_wen | dm_rd) break;
      if (cyc >= 50) begin
        timeout_fail(name);
        break;
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a transaction or a response.
  initial begin : monitor
    logic  prev_en, prev_rdy, en;
    resp_t r;
    slv_t  s;
    prev_en  = 1'b0;
    prev_rdy = 1'b0;
    forever begin
      @(negedge i_clk);
      en = dm_wen | dm_rd;
      if (m_ready != '0) begin
        if (resp_q.size() == 0) begin
          check("unexpected_ready", m_ready, '0);
        end else begin
          r = resp_q.pop_front();
          check("ready_who", m_ready, r.who);
          check("rdata", m_rdata, r.data);
        end
      end
      if (en && !prev_en) begin
        if (slv_q.size() == 0) begin
          check("unexpected_slave_txn", {dm_addr, dm_wen, dm_rd}, '0);
        end else begin
          s = slv_q.pop_front();
          check("slave_txn", {dm_addr, dm_wd, dm_wen, dm_rd, dm_be}, s);
        end
      end
      if (prev_rdy) check("idle_gap", en, 1'b0);
      prev_en  = en;
      prev_rdy = |m_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int rd_cycles, pulses, got;

    i_rst = 1'b0;
    m_addr = '0; m_wd = '0; m_be = '0; m_wen = '0; m_rd = '0;

    // Reset with both masters requesting; master 0 must win after release.
    set_m(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF);
    set_m(1, 1'b0, 1'b1, 32'h80, 32'h0, 4'hF);
    slv_q.push_back(mk_slv(32'h40, 32'h0, 1'b0, 1'b1, 4'hF));
    resp_q.push_back(mk_resp(2'b01, 32'h40));
    slv_q.push_back(mk_slv(32'h80, 32'h0, 1'b0, 1'b1, 4'hF));
    resp_q.push_back(mk_resp(2'b10, 32'h80));
    repeat (3) begin
      @(negedge i_clk);
      check("reset_outputs", {dm_wen, dm_rd, dm_addr, dm_wd, dm_be, m_ready, m_rdata}, '0);
    end
    #1 i_rst = 1'b1;
    wait_rdy(0, "reset_m0");
    #1 set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_rdy(1, "reset_m1");
    #1 set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Single read with two wait states.
    @(negedge i_clk);
    wait_states = 2;
    slv_q.push_back(mk_slv(32'h100, 32'h0, 1'b0, 1'b1, 4'hF));
    resp_q.push_back(mk_resp(2'b10, 32'h100));
    #1 set_m(1, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF);
    rd_cycles = 0;
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge i_clk);
      if (dm_rd) begin
        rd_cycles++;
        check("single_read_addr", dm_addr, 32'h100);
      end
      if (m_ready[1]) begin
        pulses++;
        break;
      end
    end
    #1 set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) begin
      @(negedge i_clk);
      if (m_ready[1]) pulses++;
    end
    check("single_read_memread_cycles", rd_cycles, 3);
    check("single_read_ready_pulses", pulses, 1);

    // Contention with a zero-wait slave.
    wait_states = 0;
`ifdef ARVI_DMEM_ARB_RR_EN
    for (int t = 0; t < 4; t++) begin
      slv_q.push_back(mk_slv((t % 2 == 0) ? 32'h200 : 32'h300, 32'h0, 1'b0, 1'b1, 4'hF));
      resp_q.push_back(mk_resp((t % 2 == 0) ? 2'b01 : 2'b10, (t % 2 == 0) ? 32'h200 : 32'h300));
    end
`else
    for (int t = 0; t < 4; t++) begin
      slv_q.push_back(mk_slv(32'h200, 32'h0, 1'b0, 1'b1, 4'hF));
      resp_q.push_back(mk_resp(2'b01, 32'h200));
    end
`endif
    #1;
    set_m(0, 1'b0, 1'b1, 32'h200, 32'h0, 4'hF);
    set_m(1, 1'b0, 1'b1, 32'h300, 32'h0, 4'hF);
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge i_clk);
      if (m_ready != '0) got++;
    end
    if (got < 4) timeout_fail("contention");
    #1;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Simultaneous write and read from one master is a write.
    @(negedge i_clk);
    wait_states = 1;
    slv_q.push_back(mk_slv(32'h400, 32'hDEADBEEF, 1'b1, 1'b0, 4'b1100));
    resp_q.push_back(mk_resp(2'b01, 32'h400));
    #1 set_m(0, 1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 4'b1100);
    wait_rdy(0, "write_read");
    #1 set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Abort: master 0 flushes mid-transaction, pending master 1 follows.
    @(negedge i_clk);
    wait_states = 5;
    slv_q.push_back(mk_slv(32'h500, 32'h0, 1'b0, 1'b1, 4'hF));
    #1 set_m(0, 1'b0, 1'b1, 32'h500, 32'h0, 4'hF);
    wait_busy("abort_grant");
    slv_q.push_back(mk_slv(32'h600, 32'h0, 1'b0, 1'b1, 4'hF));
    resp_q.push_back(mk_resp(2'b10, 32'h600));
    #1 set_m(1, 1'b0, 1'b1, 32'h600, 32'h0, 4'hF);
    @(negedge i_clk);
    #1 set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 check("abort_enables_drop", {dm_wen, dm_rd}, 2'b00);
    @(negedge i_clk);
    check("abort_idle", {dm_wen, dm_rd, m_ready}, '0);
    wait_rdy(1, "abort_m1");
    #1 set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset mid-BUSY, then a stale slave ready in IDLE.
    @(negedge i_clk);
    slv_q.push_back(mk_slv(32'h700, 32'h0, 1'b0, 1'b1, 4'hF));
    #1 set_m(0, 1'b0, 1'b1, 32'h700, 32'h0, 4'hF);
    wait_busy("midbusy_grant");
    #1;
    i_rst = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge i_clk);
    check("midbusy_reset_outputs", {dm_wen, dm_rd, dm_addr, dm_be, m_ready}, '0);
    @(negedge i_clk);
    #1;
    i_rst = 1'b1;
    force_ready = 1'b1;
    @(negedge i_clk);
    check("stale_ready", m_ready, '0);
    #1 force_ready = 1'b0;

    repeat (3) @(negedge i_clk);
    check("resp_queue_drained", resp_q.size(), 0);
    check("slave_queue_drained", slv_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
